qrs_peak_detector: RTL and testbench



---
 rtl/ecg_pkg.sv | 14 +
 rtl/qrs_peak_estimator.sv | 91 +++++++++
 rtl/qrs_peak_detector.sv | 146 ++++++++++++++
 tb/tb_qrs_peak_detector.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/ecg_pkg.sv
// Shared definitions for the ECG front-end blocks.
//   ECG_DATA_W   : default width of the unsigned feature stream
//   qrs_state_t  : QRS detector states
package ecg_pkg;

  localparam int unsigned ECG_DATA_W = 16;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    TRACK   = 2'd1,
    REFRACT = 2'd2
  } qrs_state_t;

endpackage

// File: rtl/qrs_peak_estimator.sv
// Running R-peak amplitude estimate and the detection threshold derived from it.
// Optional decay of the estimate during long silent stretches is built only when
// QRS_DECAY_EN is defined.
//   clock, reset   : system clock, synchronous active-high reset
//   in_search      : detector is in SEARCH           (QRS_DECAY_EN only)
//   quiet_sample   : SEARCH sample that did not trigger (QRS_DECAY_EN only)
//   confirm        : a peak is confirmed this clock
//   peak_in        : amplitude of the confirmed peak
//   threshold      : registered max(pk_est/2, THR_MIN)
module qrs_peak_estimator #(
  parameter int unsigned DATA_W        = 16,
  parameter int unsigned INIT_PEAK     = 1024,
`ifdef QRS_DECAY_EN
  parameter int unsigned DECAY_SAMPLES = 500,
`endif
  parameter int unsigned THR_MIN       = 64
) (
  input  logic              clock,
  input  logic              reset,
`ifdef QRS_DECAY_EN
  input  logic              in_search,
  input  logic              quiet_sample,
`endif
  input  logic              confirm,
  input  logic [DATA_W-1:0] peak_in,
  output logic [DATA_W-1:0] threshold
);

  localparam logic [DATA_W-1:0] PK_RESET  = DATA_W'(INIT_PEAK);
  localparam logic [DATA_W-1:0] THR_FLOOR = DATA_W'(THR_MIN);
  localparam logic [DATA_W-1:0] THR_RESET =
    ((INIT_PEAK >> 1) > THR_MIN) ? DATA_W'(INIT_PEAK >> 1) : THR_FLOOR;

  logic [DATA_W-1:0] pk_est;
  logic [DATA_W:0]   pk_wide;
  logic [DATA_W:0]   ema_wide;
  logic [DATA_W-1:0] ema_next;
  logic [DATA_W-1:0] pk_half;

  // 7/8 old estimate + 1/8 new peak, one bit of headroom for the intermediate sum
  always_comb begin
    pk_wide  = {1'b0, pk_est};
    ema_wide = pk_wide - (pk_wide >> 3) + ({1'b0, peak_in} >> 3);
    ema_next = ema_wide[DATA_W] ? '1 : ema_wide[DATA_W-1:0];
    pk_half  = pk_est >> 1;
  end

`ifdef QRS_DECAY_EN
  localparam int unsigned SILENT_W = $clog2(DECAY_SAMPLES + 1);

  logic [SILENT_W-1:0] silent_cnt;
  logic                decay_hit;

  always_comb begin
    decay_hit = quiet_sample && (silent_cnt == SILENT_W'(DECAY_SAMPLES - 1));
  end

  always_ff @(posedge clock) begin
    if (reset || !in_search) begin
      silent_cnt <= '0;
    end else if (decay_hit) begin
      silent_cnt <= '0;
    end else if (quiet_sample) begin
      silent_cnt <= silent_cnt + SILENT_W'(1);
    end
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      pk_est <= PK_RESET;
    end else if (confirm) begin
      pk_est <= ema_next;
`ifdef QRS_DECAY_EN
    end else if (decay_hit) begin
      pk_est <= pk_est - (pk_est >> 2);
`endif
    end
  end

  // Lags pk_est by one clock; samples are at least two clocks apart, so the
  // next comparison always sees the updated value.
  always_ff @(posedge clock) begin
    if (reset) begin
      threshold <= THR_RESET;
    end else begin
      threshold <= (pk_half > THR_FLOOR) ? pk_half : THR_FLOOR;
    end
  end

endmodule

// File: rtl/qrs_peak_detector.sv
// R-peak detector on the unsigned QRS-energy feature stream. Emits a one-clock
// heartbeat_detect pulse per confirmed peak, using an adaptive threshold, a
// refractory window and a forced confirm on overlong QRS complexes.
// Build option: define QRS_DECAY_EN to decay the peak estimate after
// DECAY_SAMPLES silent samples in SEARCH.
//   clock, reset     : system clock, synchronous active-high reset
//   sample           : one-clock strobe, feature valid (>= 2 clocks apart)
//   feature          : unsigned feature value
//   heartbeat_detect : one-clock pulse, clock after the confirming sample
//   peak_value       : amplitude of last confirmed peak
//   threshold        : current detection threshold
//   in_refractory    : high while in REFRACT
module qrs_peak_detector
  import ecg_pkg::*;
#(
  parameter int unsigned DATA_W          = ECG_DATA_W,
  parameter int unsigned INIT_PEAK       = 1024,
  parameter int unsigned THR_MIN         = 64,
  parameter int unsigned REFRACT_SAMPLES = 50,
`ifdef QRS_DECAY_EN
  parameter int unsigned DECAY_SAMPLES   = 500,
`endif
  parameter int unsigned MAX_QRS         = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              sample,
  input  logic [DATA_W-1:0] feature,
  output logic              heartbeat_detect,
  output logic [DATA_W-1:0] peak_value,
  output logic [DATA_W-1:0] threshold,
  output logic              in_refractory
);

  localparam int unsigned QRS_W  = $clog2(MAX_QRS + 1);
  localparam int unsigned REFR_W = $clog2(REFRACT_SAMPLES + 1);

  qrs_state_t        state;
  qrs_state_t        state_next;
  logic [DATA_W-1:0] max_val;
  logic [DATA_W-1:0] track_max;
  logic [QRS_W-1:0]  qrs_cnt;
  logic [QRS_W-1:0]  qrs_cnt_inc;
  logic [REFR_W-1:0] refr_cnt;
  logic              above_thr;
  logic              rising;
  logic              dropped;
  logic              confirm;
  logic              refr_done;
  logic              hb_q;

  // Candidate evaluation; rising and dropped are mutually exclusive
  always_comb begin
    above_thr   = feature > threshold;
    rising      = feature > max_val;
    dropped     = feature <= (max_val - (max_val >> 2));
    track_max   = rising ? feature : max_val;
    qrs_cnt_inc = qrs_cnt + QRS_W'(1);
    confirm     = sample && (state == TRACK) &&
                  (dropped || (qrs_cnt_inc == QRS_W'(MAX_QRS)));
    refr_done   = refr_cnt == REFR_W'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= SEARCH;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (sample) begin
      case (state)
        SEARCH:  if (above_thr) state_next = TRACK;
        TRACK:   if (confirm)   state_next = REFRACT;
        REFRACT: if (refr_done) state_next = SEARCH;
        default:                state_next = SEARCH;
      endcase
    end
  end

  always_comb begin
    in_refractory    = (state == REFRACT);
    heartbeat_detect = hb_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      max_val    <= '0;
      qrs_cnt    <= '0;
      refr_cnt   <= '0;
      peak_value <= '0;
      hb_q       <= 1'b0;
    end else begin
      hb_q <= confirm;
      if (sample) begin
        case (state)
          SEARCH: begin
            if (above_thr) begin
              max_val <= feature;
              qrs_cnt <= QRS_W'(1);
            end
          end
          TRACK: begin
            max_val <= track_max;
            if (confirm) begin
              peak_value <= track_max;
              refr_cnt   <= REFR_W'(REFRACT_SAMPLES);
              qrs_cnt    <= '0;
            end else begin
              qrs_cnt <= qrs_cnt_inc;
            end
          end
          REFRACT: begin
            refr_cnt <= refr_cnt - REFR_W'(1);
          end
          default: begin
            qrs_cnt <= '0;
          end
        endcase
      end
    end
  end

  qrs_peak_estimator #(
    .DATA_W        (DATA_W),
    .INIT_PEAK     (INIT_PEAK),
`ifdef QRS_DECAY_EN
    .DECAY_SAMPLES (DECAY_SAMPLES),
`endif
    .THR_MIN       (THR_MIN)
  ) u_estimator (
    .clock        (clock),
    .reset        (reset),
`ifdef QRS_DECAY_EN
    .in_search    (state == SEARCH),
    .quiet_sample (sample && (state == SEARCH) && !above_thr),
`endif
    .confirm      (confirm),
    .peak_in      (track_max),
    .threshold    (threshold)
  );

endmodule

// File: tb/tb_qrs_peak_detector.sv
module tb_qrs_peak_detector;

  logic        clock;
  logic        reset;
  logic        sample;
  logic [15:0] feature;
  logic        heartbeat_detect;
  logic [15:0] peak_value;
  logic [15:0] threshold;
  logic        in_refractory;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  qrs_peak_detector dut (
    .clock            (clock),
    .reset            (reset),
    .sample           (sample),
    .feature          (feature),
    .heartbeat_detect (heartbeat_detect),
    .peak_value       (peak_value),
    .threshold        (threshold),
    .in_refractory    (in_refractory)
  );

  always #5 clock = ~clock;

  // Reference model: plain bookkeeping of the detection rules
  int unsigned m_pk, m_peak, m_max, m_len, m_refr_left, m_silent;
  bit          m_tracking, m_beat;

  function automatic int unsigned model_thr();
    return (m_pk / 2 > 64) ? m_pk / 2 : 64;
  endfunction

  function automatic void model_reset();
    m_pk = 1024; m_peak = 0; m_max = 0; m_len = 0;
    m_refr_left = 0; m_silent = 0; m_tracking = 0; m_beat = 0;
  endfunction

  function automatic void model_step(input int unsigned f);
    bit done;
    done   = 0;
    m_beat = 0;
    if (m_refr_left > 0) begin
      m_refr_left = m_refr_left - 1;
    end else if (!m_tracking) begin
      if (f > model_thr()) begin
        m_tracking = 1; m_max = f; m_len = 1; m_silent = 0;
      end else begin
`ifdef QRS_DECAY_EN
        m_silent = m_silent + 1;
        if (m_silent == 500) begin
          m_pk = m_pk - m_pk / 4;
          m_silent = 0;
        end
`endif
      end
    end else begin
      if (f > m_max) begin
        m_max = f; m_len = m_len + 1;
      end else if (f <= m_max - m_max / 4) begin
        done = 1;
      end else begin
        m_len = m_len + 1;
      end
      if (done || m_len == 16) begin
        m_peak = m_max;
        m_pk = m_pk - m_pk / 8 + m_max / 8;
        if (m_pk > 65535) m_pk = 65535;
        m_tracking = 0;
        m_refr_left = 50;
        m_beat = 1;
      end
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic send(input int unsigned f);
    @(negedge clock);
    sample  = 1'b1;
    feature = f[15:0];
    model_step(f);
    @(negedge clock);
    sample = 1'b0;
    check("hb", {31'b0, heartbeat_detect}, {31'b0, m_beat});
    check("peak", {16'b0, peak_value}, m_peak);
    check("refr", {31'b0, in_refractory}, {31'b0, (m_refr_left > 0)});
    @(negedge clock);
    check("hb_clr", {31'b0, heartbeat_detect}, 32'd0);
    check("thr", {16'b0, threshold}, model_thr());
    repeat ($urandom_range(0, 2)) @(negedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset  = 1'b1;
    sample = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    model_reset();
    check("rst_hb", {31'b0, heartbeat_detect}, 32'd0);
    check("rst_peak", {16'b0, peak_value}, 32'd0);
    check("rst_thr", {16'b0, threshold}, 32'd512);
    check("rst_refr", {31'b0, in_refractory}, 32'd0);
  endtask

  initial begin
    int unsigned burst_left, burst_len, burst_amp, v, d;
    clock   = 1'b0;
    reset   = 1'b1;
    sample  = 1'b0;
    feature = '0;
    model_reset();
    do_reset();

    // Basic beat
    send(100); send(600); send(900); send(800); send(650);
    check("t2_peak", {16'b0, peak_value}, 32'd900);
    check("t2_thr", {16'b0, threshold}, 32'd504);

    // Refractory window with strong input
    for (int i = 1; i <= 49; i++) send(2000);
    check("t3_in_refr", {31'b0, in_refractory}, 32'd1);
    send(2000);
    check("t3_refr_end", {31'b0, in_refractory}, 32'd0);
    send(2000);
    send(0);
    check("t3_peak", {16'b0, peak_value}, 32'd2000);
    for (int i = 0; i < 50; i++) send(0);

    // Long QRS forced confirm
    do_reset();
    for (int i = 0; i < 16; i++) send(600 + 10 * i);
    check("t4_peak", {16'b0, peak_value}, 32'd750);
    check("t4_in_refr", {31'b0, in_refractory}, 32'd1);

    // Threshold and max equality boundaries
    do_reset();
    send(512); send(0);
    check("eq_thr_peak", {16'b0, peak_value}, 32'd0);
    send(513); send(513); send(385);
    check("eq_max_peak", {16'b0, peak_value}, 32'd513);

    // Reset in the middle of a candidate
    do_reset();
    send(600); send(900);
    do_reset();
    send(700); send(400);
    check("t6_peak", {16'b0, peak_value}, 32'd700);

    // Silent stretch
    do_reset();
    for (int i = 0; i < 500; i++) send(0);
`ifdef QRS_DECAY_EN
    check("t5_thr", {16'b0, threshold}, 32'd384);
`else
    check("t5_thr", {16'b0, threshold}, 32'd512);
`endif

    // Randomized beat-like stream
    do_reset();
    burst_left = 0; burst_len = 1; burst_amp = 0;
    for (int n = 0; n < 1500; n++) begin
      if (burst_left > 0) begin
        d = (2 * burst_left > burst_len) ? 2 * burst_left - burst_len : burst_len - 2 * burst_left;
        v = burst_amp * (burst_len - d) / burst_len + $urandom_range(0, 40);
        burst_left--;
      end else if ($urandom_range(0, 29) == 0) begin
        burst_len  = $urandom_range(2, 24);
        burst_left = burst_len;
        burst_amp  = $urandom_range(300, 4000);
        v = $urandom_range(0, 200);
      end else if ($urandom_range(0, 199) == 0) begin
        v = $urandom_range(0, 65535);
      end else begin
        v = $urandom_range(0, 200);
      end
      send(v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
